// File: rtl/pwm_duty_ramp_if.sv
// Target-request channel for pwm_duty_ramp: a new duty target and step divider
// offered with a valid/ready handshake.
interface pwm_duty_ramp_if #(
  parameter int unsigned R        = 8,
  parameter int unsigned DIV_BITS = 8
);
  logic [R:0]          target;
  logic                target_valid;
  logic                target_ready;
  logic [DIV_BITS-1:0] step_div;

  modport master (
    output target,
    output target_valid,
    output step_div,
    input  target_ready
  );

  modport slave (
    input  target,
    input  target_valid,
    input  step_div,
    output target_ready
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Ramps a PWM duty value one LSB at a time toward an accepted target, stepping
// once every step_div+1 un-held PWM-period ticks.
module pwm_duty_ramp #(
  parameter int unsigned R        = 8,
  parameter int unsigned DIV_BITS = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  pwm_duty_ramp_if.slave req,
  input  logic           tick,
  input  logic           hold,
  output logic [R:0]     duty,
  output logic           busy,
  output logic           done
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [R:0] FULL = (R+1)'(1) << R;

  state_t              state;
  logic [R:0]          tgt;
  logic [DIV_BITS-1:0] div;
  logic [DIV_BITS-1:0] cnt;
  logic                up;

  logic [R:0]          tgt_clamped;
  logic [R:0]          duty_next;
  logic                counted;

  always_comb begin
    tgt_clamped = (req.target > FULL) ? FULL : req.target;
  end

  // Direction is fixed at accept and tgt is already clamped, so a single
  // LSB step can neither overshoot tgt nor leave the 0..FULL range.
  always_comb begin
    duty_next = up ? duty + (R+1)'(1) : duty - (R+1)'(1);
  end

  always_comb begin
    counted = tick && !hold;
  end

  assign req.target_ready = (state == IDLE);
  assign busy             = (state == RAMP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      duty  <= '0;
      tgt   <= '0;
      div   <= '0;
      cnt   <= '0;
      up    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req.target_valid) begin
            tgt <= tgt_clamped;
            div <= req.step_div;
            cnt <= '0;
            if (tgt_clamped == duty) begin
              done <= 1'b1;
            end else begin
              up    <= (tgt_clamped > duty);
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (counted) begin
            if (cnt == div) begin
              cnt  <= '0;
              duty <= duty_next;
              if (duty_next == tgt) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + DIV_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: table of ramp requests plus hand-written
// hold, mid-ramp reset and first-edge-accept sequences.
module tb_pwm_duty_ramp;

  localparam int R        = 8;
  localparam int DIV_BITS = 8;

  logic         clk;
  logic         reset_n;
  logic         tick;
  logic         hold;
  logic [R:0]   duty;
  logic         busy;
  logic         done;

  pwm_duty_ramp_if #(.R(R), .DIV_BITS(DIV_BITS)) bus ();

  pwm_duty_ramp #(.R(R), .DIV_BITS(DIV_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus),
    .tick    (tick),
    .hold    (hold),
    .duty    (duty),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [R:0] tgt;
    int         div;
    int         period;
    int         exp_final;
    int         exp_ticks;
    int         exp_steps;
  } vec_t;

  vec_t vecs[7];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc, ticks, since, steps, lo, hi, dir;
    int         start;
    logic [R:0] prev;
    logic       was_busy, finished, t;
    check("ready_before_accept", int'(bus.target_ready), 1);
    start = int'(duty);
    dir   = (v.exp_final > start) ? 1 : -1;
    lo    = (v.exp_final < start) ? v.exp_final : start;
    hi    = (v.exp_final > start) ? v.exp_final : start;
    bus.target       = v.tgt;
    bus.step_div     = DIV_BITS'(v.div);
    bus.target_valid = 1'b1;
    tick             = 1'b1;
    hold             = 1'b0;
    cycle();
    bus.target_valid = 1'b0;
    tick             = 1'b0;
    if (v.exp_steps == 0) begin
      check("equal_done", int'(done), 1);
      check("equal_busy", int'(busy), 0);
      check("equal_duty", int'(duty), start);
      cycle();
      check("equal_done_once", int'(done), 0);
      check("equal_duty_hold", int'(duty), start);
      return;
    end
    check("accept_busy", int'(busy), 1);
    check("accept_duty", int'(duty), start);
    check("accept_done", int'(done), 0);
    ticks = 0; since = 0; steps = 0; cyc = 0; finished = 1'b0;
    while (!finished && cyc < 20000) begin
      cyc++;
      t        = ((cyc % v.period) == 0);
      tick     = t;
      was_busy = busy;
      prev     = duty;
      cycle();
      tick = 1'b0;
      if (t && was_busy) begin
        ticks++;
        since++;
      end
      if (duty != prev) begin
        steps++;
        check("step_size", int'(duty) - int'(prev), dir);
        check("step_interval", since, v.div + 1);
        check("no_overshoot",
              (int'(duty) >= lo && int'(duty) <= hi && int'(duty) <= 256) ? 1 : 0, 1);
        since = 0;
      end
      if (done) finished = 1'b1;
    end
    check("ramp_done_seen", int'(finished), 1);
    check("final_duty", int'(duty), v.exp_final);
    check("ramp_ticks", ticks, v.exp_ticks);
    check("ramp_steps", steps, v.exp_steps);
    check("busy_after", int'(busy), 0);
    check("ready_after", int'(bus.target_ready), 1);
    cycle();
    check("done_one_cycle", int'(done), 0);
    check("duty_stable", int'(duty), v.exp_final);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    logic finished;

    vecs[0] = '{9'd64,  0, 1,  64,  64,  64};
    vecs[1] = '{9'd32,  3, 10, 32,  128, 32};
    vecs[2] = '{9'd32,  5, 1,  32,  0,   0};
    vecs[3] = '{9'd0,   1, 2,  0,   64,  32};
    vecs[4] = '{9'd300, 0, 1,  256, 256, 256};
    vecs[5] = '{9'd256, 2, 1,  256, 0,   0};
    vecs[6] = '{9'd255, 2, 3,  255, 3,   1};

    reset_n          = 1'b0;
    tick             = 1'b0;
    hold             = 1'b0;
    bus.target       = '0;
    bus.target_valid = 1'b0;
    bus.step_div     = '0;
    #23;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(bus.target_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Hold sequence: 255 -> 200 with div 6, frozen for 20 ticks mid-ramp.
    bus.target = 9'd200; bus.step_div = 8'd6; bus.target_valid = 1'b1; tick = 1'b1;
    cycle();
    bus.target_valid = 1'b0;
    check("hold_accept_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("pre_hold_duty", int'(duty), 255);
    end
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.target_valid = (i == 10);
      bus.target       = 9'd0;
      cycle();
      check("held_duty", int'(duty), 255);
      check("held_busy", int'(busy), 1);
    end
    bus.target_valid = 1'b0;
    hold = 1'b0;
    cycle();
    check("resume_tick6", int'(duty), 255);
    cycle();
    check("resume_tick7", int'(duty), 254);
    ticks = 0; finished = 1'b0;
    for (int i = 0; i < 1000 && !finished; i++) begin
      cycle();
      ticks++;
      if (done) finished = 1'b1;
    end
    tick = 1'b0;
    check("hold_done_seen", int'(finished), 1);
    check("hold_final_duty", int'(duty), 200);
    check("hold_remaining_ticks", ticks, 378);
    cycle();

    // Asynchronous reset between edges, mid-ramp.
    bus.target = 9'd100; bus.step_div = 8'd0; bus.target_valid = 1'b1; tick = 1'b1;
    cycle();
    bus.target_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("pre_reset_duty", int'(duty), 195);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_duty", int'(duty), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(bus.target_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_done", int'(done), 0);
      check("post_rst_duty", int'(duty), 0);
      check("post_rst_busy", int'(busy), 0);
    end

    // Accept on the very first edge after reset release.
    reset_n = 1'b0;
    bus.target = 9'd5; bus.step_div = 8'd0; bus.target_valid = 1'b1; tick = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    bus.target_valid = 1'b0;
    check("first_edge_busy", int'(busy), 1);
    check("first_edge_duty", int'(duty), 0);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check("first_ramp_duty", int'(duty), k);
    end
    check("first_ramp_done", int'(done), 1);
    tick = 1'b0;
    cycle();
    check("first_ramp_done_once", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
